sw_pio_debounce: RTL and testbench

Parametrised successor to the 4-bit switch PIO input on the HPS lightweight bus. It synchronises WIDTH asynchronous switch/button inputs and debounces each channel independently. It captures rising and/or falling edges per channel and raises a maskable level interrupt. Registers are exposed through a 32-bit Avalon-MM slave with fixed read latency 1.

---
 rtl/sw_pio_debounce.sv | 126 ++++++++++++
 tb/tb_sw_pio_debounce.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sw_pio_debounce.sv
// Switch PIO: two-flop sync, per-channel debounce, edge capture, level irq.
// 32-bit Avalon-MM slave with read latency 1.
module sw_pio_debounce #(
  parameter  int WIDTH           = 4,
  parameter  int DEBOUNCE_CYCLES = 50000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] sw_export,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_db;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [31:0]      r_rdata;

  logic [WIDTH-1:0] w_hit;
  logic [WIDTH-1:0] w_db_nxt;
  logic [WIDTH-1:0] w_rise_ev;
  logic [WIDTH-1:0] w_fall_ev;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rdata;
  logic             w_wr_mask;
  logic             w_wr_cap;
  logic             w_wr_rise;
  logic             w_wr_fall;
  logic             w_unused;

  assign w_unused = ^avs_writedata;
  assign w_wdata  = avs_writedata[WIDTH-1:0];

  assign w_wr_mask = avs_write && (avs_address == 3'd1);
  assign w_wr_cap  = avs_write && (avs_address == 3'd2);
  assign w_wr_rise = avs_write && (avs_address == 3'd3);
  assign w_wr_fall = avs_write && (avs_address == 3'd4);

  // A channel flips only on its DEBOUNCE_CYCLES-th consecutive mismatch.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_hit[i] = (r_s2[i] != r_db[i]) && (r_cnt[i] == LAST);
    end
  end

  assign w_db_nxt  = r_db ^ w_hit;
  assign w_rise_ev = w_hit & w_db_nxt & r_rise;
  assign w_fall_ev = w_hit & ~w_db_nxt & r_fall;
  assign w_clr     = w_wr_cap ? w_wdata : '0;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_db <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1 <= sw_export;
      r_s2 <= r_s1;
      r_db <= w_db_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        if ((r_s2[i] == r_db[i]) || w_hit[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // New edges win over a same-cycle write-1-to-clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_cap  <= '0;
      r_mask <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_cap <= (r_cap & ~w_clr) | w_rise_ev | w_fall_ev;
      if (w_wr_mask) r_mask <= w_wdata;
      if (w_wr_rise) r_rise <= w_wdata;
      if (w_wr_fall) r_fall <= w_wdata;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (avs_address)
      3'd0:    w_rdata = 32'(r_db);
      3'd1:    w_rdata = 32'(r_mask);
      3'd2:    w_rdata = 32'(r_cap);
      3'd3:    w_rdata = 32'(r_rise);
      3'd4:    w_rdata = 32'(r_fall);
      3'd5:    w_rdata = 32'(r_s2);
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_rdata <= '0;
    end else if (avs_read) begin
      r_rdata <= w_rdata;
    end
  end

  assign avs_readdata = r_rdata;
  assign irq          = |(r_cap & r_mask);

endmodule

// File: tb/tb_sw_pio_debounce.sv
// Bench for sw_pio_debounce: directed plan steps, then random traffic,
// all checked against a sample-history reference model.
module tb_sw_pio_debounce;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw = '0;
  logic [2:0]   addr = '0;
  logic         rd = 1'b0;
  logic         wr = 1'b0;
  logic [31:0]  wd = '0;
  logic [31:0]  rdata;
  logic         irq;

  int total = 0;
  int bad = 0;

  logic [W-1:0] m_s1, m_s2, m_db, m_cap, m_mask, m_rise, m_fall;
  logic [31:0]  m_rd;
  logic [W-1:0] hist [$];

  always #5 clk = ~clk;

  sw_pio_debounce #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .sw_export(sw),
    .avs_address(addr),
    .avs_read(rd),
    .avs_write(wr),
    .avs_writedata(wd),
    .avs_readdata(rdata),
    .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_cap = '0;
    m_mask = '0; m_rise = '0; m_fall = '0; m_rd = '0;
    hist.delete();
  endtask

  function automatic logic [31:0] reg_val(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_db);
      3'd1: return 32'(m_mask);
      3'd2: return 32'(m_cap);
      3'd3: return 32'(m_rise);
      3'd4: return 32'(m_fall);
      3'd5: return 32'(m_s2);
      default: return 32'h0;
    endcase
  endfunction

  // A level is accepted once the last D synchronised samples all
  // disagree with the currently accepted level.
  task automatic tick();
    logic [W-1:0] ndb, ev, ncap;
    bit all;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      ndb = m_db;
      for (int i = 0; i < W; i++) begin
        if (hist.size() == D) begin
          all = 1'b1;
          foreach (hist[j]) if (hist[j][i] == m_db[i]) all = 1'b0;
          if (all) ndb[i] = ~m_db[i];
        end
      end
      ev = (ndb & ~m_db & m_rise) | (~ndb & m_db & m_fall);
      if (rd) m_rd = reg_val(addr);
      ncap = m_cap;
      if (wr && addr == 3'd2) ncap = ncap & ~wd[W-1:0];
      ncap = ncap | ev;
      if (wr && addr == 3'd1) m_mask = wd[W-1:0];
      if (wr && addr == 3'd3) m_rise = wd[W-1:0];
      if (wr && addr == 3'd4) m_fall = wd[W-1:0];
      m_cap = ncap;
      m_db = ndb;
      m_s2 = m_s1;
      m_s1 = sw;
    end
    #1;
    chk("irq_model", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
    chk("rdata_model", rdata, m_rd);
  endtask

  task automatic cyc(input logic [2:0] a, input logic r, input logic w,
                     input logic [31:0] d);
    addr = a; rd = r; wr = w; wd = d;
    tick();
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(3'd0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic wreg(input logic [2:0] a, input logic [31:0] d);
    cyc(a, 1'b0, 1'b1, d);
  endtask

  task automatic rreg(input logic [2:0] a);
    cyc(a, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    model_clear();
    #1;
    idle(3);
    rst_n = 1'b1;

    // reset values
    chk("reset_irq", {31'b0, irq}, 32'h0);
    for (int a = 0; a < 8; a++) begin
      rreg(3'(a));
      chk("reset_read", rdata, 32'h0);
    end

    // glitch rejection then stable step
    sw = 4'h1;
    idle(3);
    sw = 4'h0;
    idle(6);
    rreg(3'd0);
    chk("glitch_data", rdata, 32'h0);
    sw = 4'h1;
    for (int k = 1; k <= 7; k++) begin
      rreg(3'd0);
      chk("step_latency", rdata, (k == 7) ? 32'h1 : 32'h0);
    end

    // rise capture and irq
    wreg(3'd3, 32'h1);
    wreg(3'd1, 32'h1);
    sw = 4'h0;
    idle(10);
    chk("no_fall_irq", {31'b0, irq}, 32'h0);
    sw = 4'h1;
    for (int k = 1; k <= 6; k++) begin
      idle(1);
      chk("rise_irq_timing", {31'b0, irq}, (k == 6) ? 32'h1 : 32'h0);
    end
    rreg(3'd2);
    chk("rise_cap", rdata, 32'h1);
    wreg(3'd2, 32'h1);
    chk("w1c_irq", {31'b0, irq}, 32'h0);
    sw = 4'h0;
    idle(10);
    rreg(3'd2);
    chk("fall_disabled", rdata, 32'h0);

    // both edges, masked
    wreg(3'd3, 32'hF);
    wreg(3'd4, 32'hF);
    wreg(3'd1, 32'h0);
    sw = 4'h8;
    idle(8);
    sw = 4'h0;
    idle(8);
    rreg(3'd2);
    chk("both_cap", rdata, 32'h8);
    chk("both_irq_masked", {31'b0, irq}, 32'h0);
    wreg(3'd1, 32'h8);
    chk("unmask_irq", {31'b0, irq}, 32'h1);
    wreg(3'd2, 32'hF);
    wreg(3'd1, 32'h0);

    // W1C collides with a new rise on bit 2
    sw = 4'h4;
    idle(5);
    wreg(3'd2, 32'h4);
    rreg(3'd2);
    chk("w1c_collision", rdata, 32'h4);

    // simultaneous read and write returns the old value
    cyc(3'd1, 1'b1, 1'b1, 32'h5);
    chk("rw_old", rdata, 32'h0);
    rreg(3'd1);
    chk("rw_new", rdata, 32'h5);

    // reset in the middle of a transition
    wreg(3'd2, 32'hF);
    sw = 4'hF;
    idle(4);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("midreset_rdata", rdata, 32'h0);
    chk("midreset_irq", {31'b0, irq}, 32'h0);
    idle(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      rreg(3'd0);
      chk("post_reset_data", rdata, (k == 7) ? 32'hF : 32'h0);
    end
    rreg(3'd2);
    chk("post_reset_cap", rdata, 32'h0);

    // random traffic
    for (int n = 0; n < 800; n++) begin
      int op;
      if ($urandom_range(0, 5) == 0) sw = W'($urandom);
      op = $urandom_range(0, 3);
      cyc(3'($urandom), op[0], op[1], $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
